// File: rtl/sort_mem_responder.sv
// Register-array memory responder for the sort engine bus. The AR/R read path has a
// programmable latency and the AW/W/B write path is independent; SORT_MEM_BACKDOOR_EN adds bd_* ports.
module sort_mem_responder #(
    parameter int ADDR_WDTH    = 4,
    parameter int DATA_WDTH    = 32,
    parameter int RESP_WDTH    = 1,
    parameter int MEM_SIZE     = 16,
    parameter int READ_LATENCY = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 ar_valid,
    input  logic [ADDR_WDTH-1:0] ar_addr,
    output logic                 ar_ready,
    output logic                 r_valid,
    output logic [DATA_WDTH-1:0] r_data,
    output logic [RESP_WDTH-1:0] r_resp,
    input  logic                 r_ready,
    input  logic                 aw_valid,
    input  logic [ADDR_WDTH-1:0] aw_addr,
    output logic                 aw_ready,
    input  logic                 w_valid,
    input  logic [DATA_WDTH-1:0] w_data,
    output logic                 w_ready,
    output logic                 b_valid,
    output logic [RESP_WDTH-1:0] b_resp,
    input  logic                 b_ready
`ifdef SORT_MEM_BACKDOOR_EN
    ,
    input  logic                 bd_we,
    input  logic [ADDR_WDTH-1:0] bd_addr,
    input  logic [DATA_WDTH-1:0] bd_wdata,
    output logic [DATA_WDTH-1:0] bd_rdata
`endif
);

    localparam int                 DEPTH     = 2 ** ADDR_WDTH;
    localparam logic [ADDR_WDTH:0] MEM_LIMIT = (ADDR_WDTH + 1)'(MEM_SIZE);
    localparam logic [3:0]         LAT_LOAD  = 4'(READ_LATENCY - 1);
    localparam logic [RESP_WDTH-1:0] RESP_OK  = RESP_WDTH'(1);
    localparam logic [RESP_WDTH-1:0] RESP_ERR = '0;

    typedef enum logic [1:0] {R_IDLE, R_WAIT, R_RESP} r_state_t;
    typedef enum logic [1:0] {W_IDLE, W_COMMIT, W_RESP} w_state_t;

    function automatic logic in_range(input logic [ADDR_WDTH-1:0] a);
        return {1'b0, a} < MEM_LIMIT;
    endfunction

    logic [DATA_WDTH-1:0] mem_q [DEPTH];

    // A transfer happens on a rising edge where valid && ready are both 1; a valid
    // output is held with its payload stable until the matching ready is seen.
    // Every ready/valid output is forced low while rst_n is low.
    logic ar_ready_s, r_valid_s, aw_ready_s, w_ready_s, b_valid_s;
    logic ar_hs, r_hs, aw_hs, w_hs, b_hs;

    assign ar_ready = rst_n & ar_ready_s;
    assign r_valid  = rst_n & r_valid_s;
    assign aw_ready = rst_n & aw_ready_s;
    assign w_ready  = rst_n & w_ready_s;
    assign b_valid  = rst_n & b_valid_s;

    assign ar_hs = ar_valid & ar_ready;
    assign r_hs  = r_valid & r_ready;
    assign aw_hs = aw_valid & aw_ready;
    assign w_hs  = w_valid & w_ready;
    assign b_hs  = b_valid & b_ready;

    // ------------------------------------------------------------------ read path
    r_state_t             r_state_q, r_state_d;
    logic [ADDR_WDTH-1:0] r_addr_q, r_addr_d;
    logic [3:0]           r_cnt_q, r_cnt_d;
    logic [DATA_WDTH-1:0] r_data_q, r_data_d;
    logic [RESP_WDTH-1:0] r_resp_q, r_resp_d;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state_q <= R_IDLE;
        end else begin
            r_state_q <= r_state_d;
        end
    end

    always_comb begin
        r_state_d = r_state_q;
        case (r_state_q)
            R_IDLE:  if (ar_hs) r_state_d = R_WAIT;
            R_WAIT:  if (r_cnt_q == 4'd0) r_state_d = R_RESP;
            R_RESP:  if (r_hs) r_state_d = R_IDLE;
            default: r_state_d = R_IDLE;
        endcase
    end

    always_comb begin
        ar_ready_s = (r_state_q == R_IDLE);
        r_valid_s  = (r_state_q == R_RESP);
    end

    always_comb begin
        r_addr_d = r_addr_q;
        r_cnt_d  = r_cnt_q;
        r_data_d = r_data_q;
        r_resp_d = r_resp_q;
        if (ar_hs) begin
            r_addr_d = ar_addr;
            r_cnt_d  = LAT_LOAD;
        end
        if (r_state_q == R_WAIT) begin
            if (r_cnt_q == 4'd0) begin
                // Memory is sampled before any same-edge commit lands: read-before-write.
                r_data_d = in_range(r_addr_q) ? mem_q[r_addr_q] : '0;
                r_resp_d = in_range(r_addr_q) ? RESP_OK : RESP_ERR;
            end else begin
                r_cnt_d = r_cnt_q - 4'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_addr_q <= '0;
            r_cnt_q  <= '0;
            r_data_q <= '0;
            r_resp_q <= '0;
        end else begin
            r_addr_q <= r_addr_d;
            r_cnt_q  <= r_cnt_d;
            r_data_q <= r_data_d;
            r_resp_q <= r_resp_d;
        end
    end

    assign r_data = rst_n ? r_data_q : '0;
    assign r_resp = rst_n ? r_resp_q : '0;

    // ----------------------------------------------------------------- write path
    w_state_t             w_state_q, w_state_d;
    logic [ADDR_WDTH-1:0] w_addr_q, w_addr_d;
    logic [DATA_WDTH-1:0] w_data_q, w_data_d;
    logic                 aw_got_q, aw_got_d;
    logic                 w_got_q, w_got_d;
    logic [RESP_WDTH-1:0] b_resp_q, b_resp_d;
    logic                 both_captured;
    logic                 mem_we;

    assign both_captured = (aw_got_q | aw_hs) & (w_got_q | w_hs);
    assign mem_we        = rst_n & (w_state_q == W_COMMIT) & in_range(w_addr_q);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            w_state_q <= W_IDLE;
        end else begin
            w_state_q <= w_state_d;
        end
    end

    always_comb begin
        w_state_d = w_state_q;
        case (w_state_q)
            W_IDLE:   if (both_captured) w_state_d = W_COMMIT;
            W_COMMIT: w_state_d = W_RESP;
            W_RESP:   if (b_hs) w_state_d = W_IDLE;
            default:  w_state_d = W_IDLE;
        endcase
    end

    always_comb begin
        aw_ready_s = (w_state_q == W_IDLE) & ~aw_got_q;
        w_ready_s  = (w_state_q == W_IDLE) & ~w_got_q;
        b_valid_s  = (w_state_q == W_RESP);
    end

    always_comb begin
        w_addr_d = w_addr_q;
        w_data_d = w_data_q;
        aw_got_d = aw_got_q;
        w_got_d  = w_got_q;
        b_resp_d = b_resp_q;
        if (w_state_q == W_IDLE) begin
            if (aw_hs) begin
                w_addr_d = aw_addr;
                aw_got_d = 1'b1;
            end
            if (w_hs) begin
                w_data_d = w_data;
                w_got_d  = 1'b1;
            end
            if (both_captured) begin
                aw_got_d = 1'b0;
                w_got_d  = 1'b0;
            end
        end
        if (w_state_q == W_COMMIT) begin
            b_resp_d = in_range(w_addr_q) ? RESP_OK : RESP_ERR;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            w_addr_q <= '0;
            w_data_q <= '0;
            aw_got_q <= 1'b0;
            w_got_q  <= 1'b0;
            b_resp_q <= '0;
        end else begin
            w_addr_q <= w_addr_d;
            w_data_q <= w_data_d;
            aw_got_q <= aw_got_d;
            w_got_q  <= w_got_d;
            b_resp_q <= b_resp_d;
        end
    end

    assign b_resp = rst_n ? b_resp_q : '0;

    // --------------------------------------------------------------------- storage
    // Contents survive reset; the backdoor write is last so it wins on an address clash.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[w_addr_q] <= w_data_q;
        end
`ifdef SORT_MEM_BACKDOOR_EN
        if (bd_we) begin
            mem_q[bd_addr] <= bd_wdata;
        end
`endif
    end

`ifdef SORT_MEM_BACKDOOR_EN
    assign bd_rdata = mem_q[bd_addr];
`endif

endmodule

// File: tb/tb_sort_mem_responder.sv
// Self-checking bench for sort_mem_responder: directed scenarios plus random reads/writes
// checked against an array model of the memory (backdoor checks only with SORT_MEM_BACKDOOR_EN).
module tb_sort_mem_responder;

    localparam int AW  = 4;
    localparam int DW  = 32;
    localparam int MS  = 8;
    localparam int LAT = 3;

    logic          clk;
    logic          rst_n;
    logic          ar_valid;
    logic [AW-1:0] ar_addr;
    logic          ar_ready;
    logic          r_valid;
    logic [DW-1:0] r_data;
    logic [0:0]    r_resp;
    logic          r_ready;
    logic          aw_valid;
    logic [AW-1:0] aw_addr;
    logic          aw_ready;
    logic          w_valid;
    logic [DW-1:0] w_data;
    logic          w_ready;
    logic          b_valid;
    logic [0:0]    b_resp;
    logic          b_ready;
`ifdef SORT_MEM_BACKDOOR_EN
    logic          bd_we;
    logic [AW-1:0] bd_addr;
    logic [DW-1:0] bd_wdata;
    logic [DW-1:0] bd_rdata;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    logic [DW-1:0] model_mem [16];

    sort_mem_responder #(
        .ADDR_WDTH(AW), .DATA_WDTH(DW), .RESP_WDTH(1), .MEM_SIZE(MS), .READ_LATENCY(LAT)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .ar_valid(ar_valid), .ar_addr(ar_addr), .ar_ready(ar_ready),
        .r_valid(r_valid), .r_data(r_data), .r_resp(r_resp), .r_ready(r_ready),
        .aw_valid(aw_valid), .aw_addr(aw_addr), .aw_ready(aw_ready),
        .w_valid(w_valid), .w_data(w_data), .w_ready(w_ready),
        .b_valid(b_valid), .b_resp(b_resp), .b_ready(b_ready)
`ifdef SORT_MEM_BACKDOOR_EN
        ,
        .bd_we(bd_we), .bd_addr(bd_addr), .bd_wdata(bd_wdata), .bd_rdata(bd_rdata)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [DW-1:0] model_rd(input logic [AW-1:0] a);
        return (a < MS) ? model_mem[a] : '0;
    endfunction

    // lead > 0: W valid rises lead cycles before AW; lead < 0: AW leads.
    task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d, input int lead);
        int t, aw_start, w_start, stall;
        bit aw_done, w_done, hs_aw, hs_w;
        aw_start = (lead > 0) ? lead : 0;
        w_start  = (lead < 0) ? -lead : 0;
        t = 0; aw_done = 0; w_done = 0;
        while (!(aw_done && w_done) && t < 50) begin
            if (!aw_done) begin
                aw_valid = (t >= aw_start);
                aw_addr  = aw_valid ? a : AW'($urandom);
            end
            if (!w_done) begin
                w_valid = (t >= w_start);
                w_data  = w_valid ? d : $urandom;
            end
            hs_aw = aw_valid && aw_ready;
            hs_w  = w_valid && w_ready;
            tick();
            t++;
            if (hs_aw) begin aw_done = 1; aw_valid = 0; aw_addr = AW'($urandom); end
            if (hs_w)  begin w_done = 1;  w_valid = 0;  w_data = $urandom; end
        end
        check("aw_w_handshake", {aw_done, w_done}, 2'b11);
        check("commit_cycle", {b_valid, aw_ready, w_ready}, 3'b000);
        tick();
        check("b_valid_rise", b_valid, 1'b1);
        check("b_resp", b_resp, (a < MS) ? 1'b1 : 1'b0);
        stall = $urandom_range(2, 0);
        for (int s = 0; s < stall; s++) begin
            tick();
            check("b_valid_hold", {b_valid, b_resp}, {1'b1, (a < MS) ? 1'b1 : 1'b0});
        end
        b_ready = 1;
        tick();
        b_ready = 0;
        check("b_done", {b_valid, aw_ready, w_ready}, 3'b011);
        if (a < MS) model_mem[a] = d;
    endtask

    task automatic do_read(input logic [AW-1:0] a, input int stall,
                           input logic [DW-1:0] exp_d, input logic exp_r);
        int t;
        bit seen;
        ar_valid = 1; ar_addr = a; t = 0; seen = 0;
        while (!seen && t < 20) begin
            seen = ar_ready;
            tick();
            t++;
        end
        ar_valid = 0;
        ar_addr  = AW'($urandom);
        check("ar_handshake", seen, 1'b1);
        for (int i = 0; i < LAT; i++) begin
            check("r_wait", {r_valid, ar_ready}, 2'b00);
            tick();
        end
        check("r_valid_rise", {r_valid, ar_ready}, 2'b10);
        check("r_data", r_data, exp_d);
        check("r_resp", r_resp, exp_r);
        for (int s = 0; s < stall; s++) begin
            tick();
            check("r_hold", {r_valid, ar_ready, r_resp, r_data}, {1'b1, 1'b0, exp_r, exp_d});
        end
        r_ready = 1;
        tick();
        r_ready = 0;
        check("r_done", {r_valid, ar_ready}, 2'b01);
    endtask

    initial begin
        logic [DW-1:0] old5;
        rst_n = 0;
        ar_valid = 0; ar_addr = '0; r_ready = 0;
        aw_valid = 0; aw_addr = '0; w_valid = 0; w_data = '0; b_ready = 0;
`ifdef SORT_MEM_BACKDOOR_EN
        bd_we = 0; bd_addr = '0; bd_wdata = '0;
`endif
        #1;
        check("reset_handshake_outs", {ar_ready, r_valid, aw_ready, w_ready, b_valid}, 5'b00000);
        check("reset_data_outs", {r_data, r_resp, b_resp}, 34'h0);
        tick();
        tick();
        rst_n = 1;
        #1;
        check("idle_after_reset", {ar_ready, r_valid, aw_ready, w_ready, b_valid}, 5'b10110);

        // Known contents for every in-range word.
        for (int i = 0; i < MS; i++) begin
            do_write(AW'(i), $urandom, $urandom_range(4, 0) - 2);
        end

`ifdef SORT_MEM_BACKDOOR_EN
        bd_we = 1; bd_addr = 4'd3; bd_wdata = 32'h0000_00A5;
        tick();
        bd_addr = 4'd9; bd_wdata = 32'h1234_5678;
        tick();
        bd_we = 0;
        model_mem[3] = 32'h0000_00A5;
        model_mem[9] = 32'h1234_5678;
`else
        do_write(4'd3, 32'h0000_00A5, 0);
`endif

        do_read(4'd3, 0, 32'h0000_00A5, 1'b1);
        do_read(4'd3, 5, 32'h0000_00A5, 1'b1);

        do_write(4'd2, 32'h0000_0007, 2);
        do_read(4'd2, 0, 32'h0000_0007, 1'b1);

        do_read(4'd9, 1, 32'h0, 1'b0);
        do_write(4'd9, 32'hFFFF_FFFF, -1);
`ifdef SORT_MEM_BACKDOOR_EN
        bd_addr = 4'd9;
        #1;
        check("bd_oob_unchanged", bd_rdata, 32'h1234_5678);
`endif

        // Commit edge coincides with the read load edge: old value returned.
        do_write(4'd5, 32'h1, 0);
        old5 = model_mem[5];
        fork
            do_read(4'd5, 0, old5, 1'b1);
            begin
                repeat (LAT - 1) tick();
                do_write(4'd5, 32'h2, 0);
            end
        join
        do_read(4'd5, 0, 32'h2, 1'b1);

        // Reset while a read waits and a write has only its address.
        ar_valid = 1; ar_addr = 4'd6;
        aw_valid = 1; aw_addr = 4'd6;
        w_data = 32'hDEAD_BEEF;
        tick();
        ar_valid = 0; aw_valid = 0;
        check("rst_setup", {ar_ready, aw_ready, w_ready}, 3'b001);
        rst_n = 0;
        #1;
        check("mid_reset_handshake_outs", {ar_ready, r_valid, aw_ready, w_ready, b_valid}, 5'b00000);
        check("mid_reset_data_outs", {r_data, r_resp, b_resp}, 34'h0);
        tick();
        rst_n = 1;
        #1;
        check("idle_after_mid_reset", {ar_ready, r_valid, aw_ready, w_ready, b_valid}, 5'b10110);
        repeat (LAT + 1) tick();
        check("dropped_txns", {r_valid, b_valid}, 2'b00);
        do_read(4'd6, 0, model_rd(4'd6), 1'b1);

        for (int n = 0; n < 14; n++) begin
            logic [AW-1:0] a;
            a = AW'($urandom_range(15, 0));
            if ($urandom_range(1, 0) == 1) begin
                do_write(a, $urandom, $urandom_range(4, 0) - 2);
            end else begin
                do_read(a, $urandom_range(3, 0), model_rd(a), (a < MS) ? 1'b1 : 1'b0);
            end
        end

`ifdef SORT_MEM_BACKDOOR_EN
        for (int i = 0; i < MS; i++) begin
            bd_addr = AW'(i);
            #1;
            check("bd_sweep", bd_rdata, model_mem[i]);
        end
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
